// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared types and helpers for the RGMII transmit sequencer.
// Speed codes, divider selection and the captured-data bundle.
package rgmii_pkg;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10
  } speed_e;

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } spd_st_e;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } hold_t;

  // 2'b11 is an alias of the gigabit code.
  function automatic speed_e normalise_speed(
    input logic [1:0] req
  );
    speed_e s;
    unique case (1'b1)
      req[1]:            s = SPEED_1000M;
      !req[1] && req[0]: s = SPEED_100M;
      default:           s = SPEED_10M;
    endcase
    return s;
  endfunction

  // Width needed to hold both the count and the
  // largest divider value.
  function automatic int cnt_width(
    input int d10
  );
    return $clog2(d10 + 1);
  endfunction

  function automatic int div_for_speed(
    input speed_e s,
    input int     d100,
    input int     d10
  );
    int d;
    unique case (s)
      SPEED_1000M: d = 1;
      SPEED_100M:  d = d100;
      default:     d = d10;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/rgmii_tx_rate_ctrl_if.sv
// rgmii_tx_rate_ctrl_if: MAC-side GMII bundle.
// The MAC (master) presents data; the sequencer (slave) strobes it.
interface rgmii_tx_rate_ctrl_if;

  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       gmii_clk_en;

  modport master (
    output gmii_txd,
    output gmii_tx_en,
    output gmii_tx_er,
    input  gmii_clk_en
  );

  modport slave (
    input  gmii_txd,
    input  gmii_tx_en,
    input  gmii_tx_er,
    output gmii_clk_en
  );

endinterface

// File: rtl/rgmii_txc_phase_gen.sv
// rgmii_txc_phase_gen: per-TXC-period counter and DDR clock pattern.
// TXC is high for half-cycle index h < div, giving 50% duty for odd div.
module rgmii_txc_phase_gen #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_div,
  input  logic         i_restart,
  output logic [W-1:0] o_count_nxt,
  output logic         o_wrap,
  output logic         o_txc_d1,
  output logic         o_txc_d2
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic         w_last;
  logic [W:0]   w_h1;
  logic [W:0]   w_h2;
  logic [W:0]   w_div_x;

  assign w_last  = (r_count == i_div - W'(1));
  assign w_h1    = {r_count, 1'b0};
  assign w_h2    = {r_count, 1'b1};
  assign w_div_x = {1'b0, i_div};

  // Next count: wrap at div-1, or restart on a speed switch.
  always_comb begin
    w_count_nxt = r_count + W'(1);
    if (i_restart || w_last) begin
      w_count_nxt = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign o_count_nxt = w_count_nxt;
  assign o_wrap      = w_last;
  assign o_txc_d1    = (w_h1 < w_div_x);
  assign o_txc_d2    = (w_h2 < w_div_x);

endmodule

// File: rtl/rgmii_tx_rate_ctrl.sv
// rgmii_tx_rate_ctrl: multi-rate RGMII TX sequencer (GMII in, DDR pairs out).
// Optional: RGMII_TX_BYTE_SPLIT_EN sends full bytes as two nibbles at 10/100M.
module rgmii_tx_rate_ctrl
  import rgmii_pkg::*;
#(
  parameter int         DIV_100M   = 5,
  parameter int         DIV_10M    = 50,
  parameter logic [1:0] SPEED_INIT = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_speed_req,
  rgmii_tx_rate_ctrl_if.slave gmii,
  output logic [3:0] o_txd_d1,
  output logic [3:0] o_txd_d2,
  output logic       o_ctl_d1,
  output logic       o_ctl_d2,
  output logic       o_txc_d1,
  output logic       o_txc_d2,
  output logic [1:0] o_speed_cur,
  output logic       o_speed_pending
);

  localparam int W = cnt_width(DIV_10M);

  speed_e       r_speed;
  speed_e       w_speed_nxt;
  speed_e       w_req;
  spd_st_e      r_state;
  spd_st_e      w_state_nxt;
  hold_t        r_hold;
  logic         r_clk_en;
  logic [W-1:0] w_div;
  logic [W-1:0] w_div_nxt;
  logic [W-1:0] w_count_nxt;
  logic         w_wrap;
  logic         w_txc_d1;
  logic         w_txc_d2;
  logic         w_gig;
  logic         w_gig_nxt;
  logic         w_nib_ok;
  logic         w_apply;
  logic         w_strobe;
  logic         w_clk_en_nxt;
  logic [3:0]   w_nib;

  assign w_req     = normalise_speed(i_speed_req);
  assign w_div     = W'(div_for_speed(r_speed, DIV_100M, DIV_10M));
  assign w_div_nxt = W'(div_for_speed(w_speed_nxt, DIV_100M, DIV_10M));
  assign w_gig     = (r_speed == SPEED_1000M);
  assign w_gig_nxt = (w_speed_nxt == SPEED_1000M);

  // A switch lands only on a period boundary with the line idle
  // both in the hold register and on the MAC input.
  assign w_apply = (r_state == ST_PENDING) && w_wrap
                   && !r_hold.en && !gmii.gmii_tx_en
                   && w_nib_ok;

  // The idle slot consumed by a switch is not offered to the MAC.
  assign w_strobe         = r_clk_en & ~w_apply;
  assign gmii.gmii_clk_en = w_strobe;

  // Speed FSM: track a differing request, drop it if it reverts.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_speed;
    case (r_state)
      ST_STABLE: begin
        if (w_req != r_speed) begin
          w_state_nxt = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (w_req == r_speed) begin
          w_state_nxt = ST_STABLE;
        end else if (w_apply) begin
          w_state_nxt = ST_STABLE;
          w_speed_nxt = w_req;
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  rgmii_txc_phase_gen #(
    .W (W)
  ) u_phase (
    .clk         (clk),
    .rst         (rst),
    .i_div       (w_div),
    .i_restart   (w_apply),
    .o_count_nxt (w_count_nxt),
    .o_wrap      (w_wrap),
    .o_txc_d1    (w_txc_d1),
    .o_txc_d2    (w_txc_d2)
  );

`ifdef RGMII_TX_BYTE_SPLIT_EN
  logic r_nib;
  logic w_nib_nxt;

  assign w_nib_ok = w_gig | r_nib;

  // Nibble phase: low half in the first period, high in the second.
  always_comb begin
    w_nib_nxt = r_nib;
    if (w_apply) begin
      w_nib_nxt = 1'b0;
    end else if (w_wrap && !w_gig) begin
      w_nib_nxt = ~r_nib;
    end
  end

  assign w_clk_en_nxt = (w_count_nxt == w_div_nxt - W'(1))
                        && (w_gig_nxt || w_nib_nxt);
  assign w_nib = r_nib ? r_hold.txd[7:4] : r_hold.txd[3:0];

  // Nibble phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nib <= 1'b0;
    end else begin
      r_nib <= w_nib_nxt;
    end
  end
`else
  assign w_nib_ok     = 1'b1;
  assign w_clk_en_nxt = (w_count_nxt == w_div_nxt - W'(1));
  assign w_nib        = r_hold.txd[3:0];
`endif

  // Speed, FSM state, MAC strobe and captured data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_speed  <= normalise_speed(SPEED_INIT);
      r_state  <= ST_STABLE;
      r_clk_en <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_speed  <= w_speed_nxt;
      r_state  <= w_state_nxt;
      r_clk_en <= w_clk_en_nxt;
      if (w_strobe) begin
        r_hold <= '{txd: gmii.gmii_txd,
                    en:  gmii.gmii_tx_en,
                    er:  gmii.gmii_tx_er};
      end
    end
  end

  // DDR data/control pairs from the hold register.
  always_comb begin
    o_txd_d1 = r_hold.txd[3:0];
    o_txd_d2 = r_hold.txd[7:4];
    o_ctl_d1 = r_hold.en;
    o_ctl_d2 = r_hold.en ^ r_hold.er;
    if (!w_gig) begin
      o_txd_d1 = w_nib;
      o_txd_d2 = w_nib;
      o_ctl_d1 = w_txc_d1 ? r_hold.en
                          : r_hold.en ^ r_hold.er;
      o_ctl_d2 = w_txc_d2 ? r_hold.en
                          : r_hold.en ^ r_hold.er;
    end
  end

  assign o_txc_d1        = w_txc_d1;
  assign o_txc_d2        = w_txc_d2;
  assign o_speed_cur     = r_speed;
  assign o_speed_pending = (r_state == ST_PENDING);

endmodule
